mul_ss_pipe: RTL and testbench

Parametrised, pipelined signed×signed multiplier with valid/ready flow control, overflow detection and an optional saturating output stage. It is the registered successor to the combinational `NUM_STAGE = 0` multiplier cores emitted for the synthetic cases. It sits between HLS-generated datapath stages that need to meet timing at wider operand widths and to tolerate downstream backpressure.

---
 rtl/mul_ss_pipe_pkg.sv | 33 +++
 rtl/mul_ss_pipe_stage.sv | 25 ++
 rtl/mul_ss_pipe.sv | 81 ++++++++
 tb/tb_mul_ss_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ss_pipe_pkg.sv
// Shared constants and range helpers for the pipelined signed multiplier.
// Values are passed sign-extended to 64 bits so one helper serves every width.
package mul_ss_pipe_pkg;

    localparam int MUL_MAX_STAGE = 8;
    localparam int MUL_VAL_W     = 64;

    // Returns 1 when value lies within the signed range of a width-bit word.
    function automatic logic mul_fits(input logic signed [MUL_VAL_W-1:0] value,
                                      input int width);
        logic signed [MUL_VAL_W-1:0] hi;
        logic signed [MUL_VAL_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return (value >= lo) && (value <= hi);
    endfunction

    function automatic logic signed [MUL_VAL_W-1:0] mul_clamp(input logic signed [MUL_VAL_W-1:0] value,
                                                              input int width);
        logic signed [MUL_VAL_W-1:0] hi;
        logic signed [MUL_VAL_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mul_ss_pipe_stage.sv
// One register slice of the multiplier pipeline: data word plus valid bit.
// Holds its contents whenever ce is low.
module mul_ss_pipe_stage #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            q_vld <= 1'b0;
        end else if (ce) begin
            q     <= d;
            q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/mul_ss_pipe.sv
// Pipelined signed x signed multiplier with valid/ready flow control and overflow flag.
// Define MUL_SAT_EN to clamp overflowing results instead of wrapping to the low bits.
module mul_ss_pipe
    import mul_ss_pipe_pkg::*;
#(
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 9,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_ovf,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int P     = din0_WIDTH + din1_WIDTH;
    // Out-of-range depths are pulled back into 1..MUL_MAX_STAGE.
    localparam int DEPTH = (NUM_STAGE < 1) ? 1 :
                           ((NUM_STAGE > MUL_MAX_STAGE) ? MUL_MAX_STAGE : NUM_STAGE);

    logic signed [P-1:0] a_ext;
    logic signed [P-1:0] b_ext;
    logic signed [P-1:0] prod;
    logic        [P-1:0] data [0:DEPTH];
    logic                vld  [0:DEPTH];
    logic                ce;
    logic signed [P-1:0] last;
    logic signed [MUL_VAL_W-1:0] ext;
    logic                fits;

    // Operands are sign-extended to P bits so the P-bit product is exact.
    assign a_ext = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
    assign b_ext = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
    assign prod  = a_ext * b_ext;

    assign data[0] = prod;
    assign vld[0]  = din_valid;

    assign ce        = !(vld[DEPTH] && !dout_ready);
    assign din_ready = ce && ap_rst_n;

    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        mul_ss_pipe_stage #(
            .WIDTH(P)
        ) u_stage (
            .clk  (ap_clk),
            .rst_n(ap_rst_n),
            .ce   (ce),
            .d    (data[i-1]),
            .d_vld(vld[i-1]),
            .q    (data[i]),
            .q_vld(vld[i])
        );
    end

    assign last = data[DEPTH];
    assign ext  = 64'(last);
    assign fits = mul_fits(ext, dout_WIDTH);

    assign dout_ovf   = !fits;
    assign dout_valid = vld[DEPTH];

`ifdef MUL_SAT_EN
    logic signed [MUL_VAL_W-1:0] clamped;

    always_comb begin
        clamped = mul_clamp(ext, dout_WIDTH);
        dout    = clamped[dout_WIDTH-1:0];
    end
`else
    assign dout = last[dout_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_mul_ss_pipe.sv
// Self-checking bench for mul_ss_pipe: directed vector table, reset/backpressure
// sequences and randomized traffic checked against an arithmetic reference model.
module tb_mul_ss_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Default 9/9/9, two stages
    logic [8:0] a0 = '0, b0 = '0;
    logic       v0 = 1'b0, dr0 = 1'b0;
    logic       r0, o0, dv0;
    logic [8:0] d0;

    // 9/9/9, three stages
    logic [8:0] a3 = '0, b3 = '0;
    logic       v3 = 1'b0, dr3 = 1'b1;
    logic       r3, o3, dv3;
    logic [8:0] d3;

    // 16/12/28, one stage
    logic [15:0] aw = '0;
    logic [11:0] bw = '0;
    logic        vw = 1'b0, drw = 1'b0;
    logic        rw, ow, dvw;
    logic [27:0] dw;

    mul_ss_pipe #(.din0_WIDTH(9), .din1_WIDTH(9), .dout_WIDTH(9), .NUM_STAGE(2)) u_dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(a0), .din1(b0), .din_valid(v0), .din_ready(r0),
        .dout(d0), .dout_ovf(o0), .dout_valid(dv0), .dout_ready(dr0));

    mul_ss_pipe #(.din0_WIDTH(9), .din1_WIDTH(9), .dout_WIDTH(9), .NUM_STAGE(3)) u_dut3 (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(a3), .din1(b3), .din_valid(v3), .din_ready(r3),
        .dout(d3), .dout_ovf(o3), .dout_valid(dv3), .dout_ready(dr3));

    mul_ss_pipe #(.din0_WIDTH(16), .din1_WIDTH(12), .dout_WIDTH(28), .NUM_STAGE(1)) u_wide (
        .ap_clk(clk), .ap_rst_n(rst_n), .din0(aw), .din1(bw), .din_valid(vw), .din_ready(rw),
        .dout(dw), .dout_ovf(ow), .dout_valid(dvw), .dout_ready(drw));

    int checks = 0;
    int passes = 0;

    typedef struct {
        longint d;
        bit     o;
    } exp_t;

    typedef struct {
        string      name;
        logic [8:0] a;
        logic [8:0] b;
        longint     expDout;
        bit         expOvf;
    } vec_t;

    exp_t q0[$];
    exp_t qw[$];
    vec_t vecs[8];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact product, then range test and wrap or clamp by plain arithmetic
    function automatic exp_t refModel(input longint a, input longint b, input int w);
        exp_t   e;
        longint p, span, hi, lo, r;
        p    = a * b;
        span = longint'(1) << w;
        hi   = span / 2 - 1;
        lo   = -(span / 2);
        e.o  = (p > hi) || (p < lo);
`ifdef MUL_SAT_EN
        e.d = (p > hi) ? hi : ((p < lo) ? lo : p);
`else
        r = p % span;
        if (r < 0) r += span;
        if (r > hi) r -= span;
        e.d = r;
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic [8:0] a, input logic [8:0] b, input logic v, input logic r);
        @(posedge clk);
        #1;
        a0  = a;
        b0  = b;
        v0  = v;
        dr0 = r;
    endtask

    // Scoreboard and hold-stability monitor for the default instance
    bit     holdValid = 0;
    longint holdD;
    bit     holdO;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            holdValid = 0;
        end else begin
            if (holdValid) begin
                checkOutput("hold_valid", dv0, 1);
                checkOutput("hold_dout", longint'($signed(d0)), holdD);
                checkOutput("hold_ovf", o0, holdO);
            end
            holdValid = dv0 && !dr0;
            holdD     = longint'($signed(d0));
            holdO     = o0;
            if (dv0 && dr0) begin
                if (q0.size() == 0) begin
                    checkOutput("sb0_spurious_valid", dv0, 0);
                end else begin
                    e = q0.pop_front();
                    checkOutput("sb0_dout", longint'($signed(d0)), e.d);
                    checkOutput("sb0_ovf", o0, e.o);
                end
            end
            if (v0 && r0) begin
                q0.push_back(refModel(longint'($signed(a0)), longint'($signed(b0)), 9));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            qw.delete();
        end else begin
            if (dvw && drw) begin
                if (qw.size() == 0) begin
                    checkOutput("sbw_spurious_valid", dvw, 0);
                end else begin
                    e = qw.pop_front();
                    checkOutput("sbw_dout", longint'($signed(dw)), e.d);
                    checkOutput("sbw_ovf", ow, e.o);
                    checkOutput("sbw_ovf_zero", ow, 0);
                end
            end
            if (vw && rw) begin
                qw.push_back(refModel(longint'($signed(aw)), longint'($signed(bw)), 28));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;

        vecs[0] = '{"3x-5",      9'sd3,    -9'sd5,   -15, 1'b0};
        vecs[1] = '{"7x7",       9'sd7,    9'sd7,    49,  1'b0};
        vecs[2] = '{"15x17_max", 9'sd15,   9'sd17,   255, 1'b0};
        vecs[3] = '{"-16x16_min",-9'sd16,  9'sd16,   -256,1'b0};
`ifdef MUL_SAT_EN
        vecs[4] = '{"-256x-256", -9'sd256, -9'sd256, 255,  1'b1};
        vecs[5] = '{"16x16",     9'sd16,   9'sd16,   255,  1'b1};
        vecs[6] = '{"255x-2",    9'sd255,  -9'sd2,   -256, 1'b1};
        vecs[7] = '{"-256x255",  -9'sd256, 9'sd255,  -256, 1'b1};
`else
        vecs[4] = '{"-256x-256", -9'sd256, -9'sd256, 0,    1'b1};
        vecs[5] = '{"16x16",     9'sd16,   9'sd16,   -256, 1'b1};
        vecs[6] = '{"255x-2",    9'sd255,  -9'sd2,   2,    1'b1};
        vecs[7] = '{"-256x255",  -9'sd256, 9'sd255,  -256, 1'b1};
`endif

        // Reset values with downstream ready high
        dr0 = 1'b1;
        v0  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dout_valid", dv0, 0);
        checkOutput("rst_dout", longint'($signed(d0)), 0);
        checkOutput("rst_ovf", o0, 0);
        checkOutput("rst_din_ready", r0, 0);
        checkOutput("rst_dout_valid3", dv3, 0);
        checkOutput("rst_dout_valid_w", dvw, 0);
        v0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("din_ready_after_reset", r0, 1);

        // Latency and ordering on the three-stage instance
        @(posedge clk); #1;
        a3 = 9'sd3; b3 = -9'sd5; v3 = 1'b1;
        @(posedge clk); #1;
        a3 = 9'sd7; b3 = 9'sd7;
        @(posedge clk); #1;
        v3 = 1'b0;
        checkOutput("lat_not_early", dv3, 0);
        @(posedge clk); #1;
        checkOutput("lat_valid1", dv3, 1);
        checkOutput("lat_dout1", longint'($signed(d3)), -15);
        checkOutput("lat_ovf1", o3, 0);
        @(posedge clk); #1;
        checkOutput("lat_valid2", dv3, 1);
        checkOutput("lat_dout2", longint'($signed(d3)), 49);
        checkOutput("lat_ovf2", o3, 0);
        @(posedge clk); #1;
        checkOutput("lat_drained", dv3, 0);

        // Directed vector table, one isolated transfer per entry
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a3 = vecs[i].a; b3 = vecs[i].b; v3 = 1'b1;
            @(posedge clk); #1;
            v3  = 1'b0;
            cnt = 1;
            while (!dv3 && cnt < 10) begin
                @(posedge clk); #1;
                cnt++;
            end
            checkOutput({vecs[i].name, "_latency"}, cnt, 3);
            checkOutput({vecs[i].name, "_dout"}, longint'($signed(d3)), vecs[i].expDout);
            checkOutput({vecs[i].name, "_ovf"}, o3, vecs[i].expOvf);
            @(posedge clk); #1;
        end

        // Backpressure: fill both stages, stall 5 cycles, then release
        applyStimulus(9'sd5, 9'sd6, 1'b1, 1'b0);
        applyStimulus(-9'sd7, 9'sd8, 1'b1, 1'b0);
        applyStimulus(9'sd20, 9'sd20, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_din_ready", r0, 0);
            checkOutput("bp_dout_valid", dv0, 1);
            @(posedge clk); #1;
        end
        dr0 = 1'b1;
        #1;
        checkOutput("bp_release_ready", r0, 1);
        checkOutput("bp_out1_valid", dv0, 1);
        applyStimulus(9'sd0, 9'sd0, 1'b0, 1'b1);
        checkOutput("bp_out2_valid", dv0, 1);
        @(posedge clk); #1;
        checkOutput("bp_out3_valid", dv0, 1);
        @(posedge clk); #1;
        checkOutput("bp_empty", dv0, 0);

        // Reset with two results in flight
        applyStimulus(9'sd9, 9'sd9, 1'b1, 1'b1);
        applyStimulus(-9'sd3, 9'sd4, 1'b1, 1'b1);
        @(posedge clk); #1;
        v0    = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dout_valid", dv0, 0);
        checkOutput("midrst_dout", longint'($signed(d0)), 0);
        checkOutput("midrst_din_ready", r0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("postrst_no_output", dv0, 0);
        end

        // Randomized traffic on the default and wide instances
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            a0  = 9'($urandom);
            b0  = 9'($urandom);
            v0  = ($urandom_range(9, 0) < 7);
            dr0 = ($urandom_range(9, 0) < 7);
            aw  = 16'($urandom);
            bw  = 12'($urandom);
            vw  = ($urandom_range(9, 0) < 7);
            drw = ($urandom_range(9, 0) < 6);
        end
        @(posedge clk); #1;
        v0 = 1'b0; dr0 = 1'b1; vw = 1'b0; drw = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("sb0_drained", q0.size(), 0);
        checkOutput("sbw_drained", qw.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
